// File: rtl/mod_seq_pkg.sv
// Shared types for the modulation sequencer: FSM states, Mod select codes,
// the step-table record and the settle-length helper.
package mod_seq_pkg;

    // Table durations are stored at this width; DUR_W must not exceed it.
    localparam int DUR_W_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] MODE_SUM  = 3'b000;
    localparam logic [2:0] MODE_DIFF = 3'b001;
    localparam logic [2:0] MODE_ADD  = 3'b010;
    localparam logic [2:0] MODE_MULT = 3'b011;
    localparam logic [2:0] MODE_OSC0 = 3'b100;
    localparam logic [2:0] MODE_OSC1 = 3'b101;
    localparam logic [2:0] MODE_XOR  = 3'b110;
    localparam logic [2:0] MODE_AND  = 3'b111;

    typedef struct packed {
        logic [2:0]           mode;
        logic [DUR_W_MAX-1:0] dur;
    } step_t;

    // The multiplier path is pipelined; every other mode settles in one clock.
    function automatic int unsigned settle_len(input logic [2:0] mode, input int unsigned mult_lat);
        return (mode == MODE_MULT) ? mult_lat : 1;
    endfunction

endpackage

// File: rtl/mod_seq_if.sv
// Control/config/status bundle between the synth control registers (master)
// and the modulation sequencer (slave).
interface mod_seq_if #(
    parameter int STEPS = 8,
    parameter int DUR_W = 8
);
    localparam int AW = $clog2(STEPS);

    logic             sample_tick;
    logic             start;
    logic             stop;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [2:0]       cfg_mode;
    logic [DUR_W-1:0] cfg_dur;
    logic [AW-1:0]    last_step;

    logic [2:0]       modulation_select;
    logic             mod_valid;
    logic [AW-1:0]    step_idx;
    logic             busy;
    logic             done;

    // start/stop are single-cycle pulses; mod_valid=1 means the Mod output for
    // modulation_select is settled and may be consumed every clock it stays high.
    modport master (
        output sample_tick, start, stop, cfg_we, cfg_addr, cfg_mode, cfg_dur, last_step,
        input  modulation_select, mod_valid, step_idx, busy, done
    );

    modport slave (
        input  sample_tick, start, stop, cfg_we, cfg_addr, cfg_mode, cfg_dur, last_step,
        output modulation_select, mod_valid, step_idx, busy, done
    );

endinterface

// File: rtl/mod_seq_timer.sv
// Loadable down-counter with an enable; o_zero flags the enabled cycle that
// takes the count from 1 to 0, so the owner can act on that same edge.
module mod_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = i_en && (r_count == W'(1));

endmodule

// File: rtl/mod_sequencer.sv
// Steps the Mod select through a programmable table, holding mod_valid low
// while Mod settles. Define MOD_SEQ_LOOP_EN to wrap forever instead of ending in DONE.
module mod_sequencer
    import mod_seq_pkg::*;
#(
    parameter int STEPS    = 8,
    parameter int DUR_W    = 8,
    parameter int MULT_LAT = 2
) (
    input  logic     clk,
    input  logic     reset,
    mod_seq_if.slave bus,
    output state_t   o_dbg_state
);

    localparam int AW    = $clog2(STEPS);
    localparam int SET_W = $clog2(MULT_LAT + 1);

    step_t                r_table [STEPS];
    state_t               r_state;
    logic [2:0]           r_mod_sel;
    logic                 r_mod_valid;
    logic [AW-1:0]        r_step_idx;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_start_ok;
    logic                 w_at_last;
    logic                 w_advance;
    logic [AW-1:0]        w_next_idx;
    logic [AW-1:0]        w_entry_idx;
    logic [2:0]           w_entry_mode;
    logic                 w_settle_load;
    logic [SET_W-1:0]     w_settle_val;
    logic                 w_settle_en;
    logic                 w_set_zero;
    logic                 w_dur_load;
    logic [DUR_W_MAX-1:0] w_dur_raw;
    logic [DUR_W_MAX-1:0] w_dur_val;
    logic                 w_dur_en;
    logic                 w_dur_zero;

    always_comb begin
        w_start_ok = bus.start && !bus.stop && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_at_last  = (r_step_idx == bus.last_step);
`ifdef MOD_SEQ_LOOP_EN
        w_next_idx = w_at_last ? '0 : r_step_idx + AW'(1);
        w_advance  = (r_state == ST_RUN) && w_dur_zero && !bus.stop;
`else
        w_next_idx = r_step_idx + AW'(1);
        w_advance  = (r_state == ST_RUN) && w_dur_zero && !bus.stop && !w_at_last;
`endif
        // The mode is read from the table only at the moment a step is entered.
        w_entry_idx   = w_start_ok ? '0 : w_next_idx;
        w_entry_mode  = r_table[w_entry_idx].mode;
        w_settle_load = w_start_ok || w_advance;
        w_settle_val  = SET_W'(settle_len(w_entry_mode, MULT_LAT));
        w_settle_en   = (r_state == ST_SETTLE);
        w_dur_load    = (r_state == ST_SETTLE) && w_set_zero && !bus.stop;
        w_dur_raw     = r_table[r_step_idx].dur;
        w_dur_val     = (w_dur_raw == '0) ? DUR_W_MAX'(1) : w_dur_raw;
        w_dur_en      = (r_state == ST_RUN) && bus.sample_tick;
    end

    mod_seq_timer #(.W(SET_W)) u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_settle_load),
        .i_load_val (w_settle_val),
        .i_en       (w_settle_en),
        .o_zero     (w_set_zero)
    );

    mod_seq_timer #(.W(DUR_W_MAX)) u_dur_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_dur_load),
        .i_load_val (w_dur_val),
        .i_en       (w_dur_en),
        .o_zero     (w_dur_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                r_table[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            r_table[bus.cfg_addr] <= step_t'{mode: bus.cfg_mode, dur: DUR_W_MAX'(bus.cfg_dur)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mod_sel   <= '0;
            r_mod_valid <= 1'b0;
            r_step_idx  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (bus.stop) begin
            r_state     <= ST_IDLE;
            r_mod_sel   <= '0;
            r_mod_valid <= 1'b0;
            r_step_idx  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state     <= ST_SETTLE;
                        r_step_idx  <= '0;
                        r_mod_sel   <= w_entry_mode;
                        r_mod_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (w_set_zero) begin
                        r_state     <= ST_RUN;
                        r_mod_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_advance) begin
                        r_state     <= ST_SETTLE;
                        r_step_idx  <= w_next_idx;
                        r_mod_sel   <= w_entry_mode;
                        r_mod_valid <= 1'b0;
                    end
`ifndef MOD_SEQ_LOOP_EN
                    else if (w_dur_zero) begin
                        // Last step expired: hold its mode and stay valid.
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.modulation_select = r_mod_sel;
    assign bus.mod_valid         = r_mod_valid;
    assign bus.step_idx          = r_step_idx;
    assign bus.busy              = r_busy;
    assign bus.done              = r_done;
    assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_mod_sequencer.sv
// Directed bench for mod_sequencer; each mod_valid rise is scored against the
// queued {step_idx, mode} expected for that step. Follows MOD_SEQ_LOOP_EN.
`timescale 1ns/1ps
module tb_mod_sequencer;
    import mod_seq_pkg::*;

    localparam int STEPS    = 8;
    localparam int DUR_W    = 8;
    localparam int MULT_LAT = 2;
    localparam int AW       = $clog2(STEPS);
    localparam int SW       = AW + 3;

    logic   clk = 1'b0;
    logic   reset;
    state_t dbg_state;

    mod_seq_if #(.STEPS(STEPS), .DUR_W(DUR_W)) bus ();

    mod_sequencer #(.STEPS(STEPS), .DUR_W(DUR_W), .MULT_LAT(MULT_LAT)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] sb_exp;
    logic        prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input int idx, input logic [2:0] mode);
        exp_q.push_back({AW'(idx), mode});
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_step(input int addr, input logic [2:0] mode, input int dur);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_mode = mode;
        bus.cfg_dur  = DUR_W'(dur);
        step(1);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
    endtask

    task automatic tick();
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sel"},   32'(bus.modulation_select), 32'(0));
        check({tag, "_valid"}, 32'(bus.mod_valid), 32'(0));
        check({tag, "_idx"},   32'(bus.step_idx), 32'(0));
        check({tag, "_busy"},  32'(bus.busy), 32'(0));
        check({tag, "_done"},  32'(bus.done), 32'(0));
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Scoreboard: every settle completion must match the next queued step.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.mod_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_rise", 32'(exp_q.size()), 32'(1));
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("sb_step", 32'({bus.step_idx, bus.modulation_select}), 32'(sb_exp));
                end
            end
            prev_valid = bus.mod_valid;
        end
    end

    initial begin
        reset           = 1'b1;
        bus.sample_tick = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_mode    = '0;
        bus.cfg_dur     = '0;
        bus.last_step   = '0;
        step(3);
        check_idle("rst");
        reset = 1'b0;
        step(1);

        // Two-step table with a multiply step
        write_step(0, MODE_SUM, 2);
        write_step(1, MODE_MULT, 1);
        bus.last_step = AW'(1);
        push_exp(0, MODE_SUM);
        push_exp(1, MODE_MULT);
        pulse_start();
        check("t2_sel0", 32'(bus.modulation_select), 32'(MODE_SUM));
        check("t2_valid_settle", 32'(bus.mod_valid), 32'(0));
        check("t2_state_settle", 32'(dbg_state), 32'(ST_SETTLE));
        check("t2_busy", 32'(bus.busy), 32'(1));
        step(1);
        check("t2_valid_rise", 32'(bus.mod_valid), 32'(1));
        check("t2_state_run", 32'(dbg_state), 32'(ST_RUN));
        tick();
        check("t2_hold_sel", 32'(bus.modulation_select), 32'(MODE_SUM));
        check("t2_hold_valid", 32'(bus.mod_valid), 32'(1));
        tick();
        check("t2_sel1", 32'(bus.modulation_select), 32'(MODE_MULT));
        check("t2_idx1", 32'(bus.step_idx), 32'(1));
        check("t2_mult_valid_a", 32'(bus.mod_valid), 32'(0));
        step(1);
        check("t2_mult_valid_b", 32'(bus.mod_valid), 32'(0));
        step(1);
        check("t2_mult_valid_rise", 32'(bus.mod_valid), 32'(1));
        tick();
`ifdef MOD_SEQ_LOOP_EN
        check("t2_wrap_sel", 32'(bus.modulation_select), 32'(MODE_SUM));
        check("t2_wrap_idx", 32'(bus.step_idx), 32'(0));
        check("t2_wrap_valid", 32'(bus.mod_valid), 32'(0));
        check("t2_wrap_done", 32'(bus.done), 32'(0));
        pulse_stop();
`else
        check("t2_done", 32'(bus.done), 32'(1));
        check("t2_done_sel", 32'(bus.modulation_select), 32'(MODE_MULT));
        check("t2_done_valid", 32'(bus.mod_valid), 32'(1));
        check("t2_done_busy", 32'(bus.busy), 32'(0));
        check("t2_done_state", 32'(dbg_state), 32'(ST_DONE));
`endif

        // Stop while running step 1
        push_exp(0, MODE_SUM);
        push_exp(1, MODE_MULT);
        pulse_start();
        step(1);
        tick();
        tick();
        step(2);
        check("t3_state_run", 32'(dbg_state), 32'(ST_RUN));
        check("t3_idx1", 32'(bus.step_idx), 32'(1));
        pulse_stop();
        check_idle("t3");

        // start and stop together from IDLE
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_idle("t4");
        step(2);
        check("t4_still_idle", 32'(dbg_state), 32'(ST_IDLE));

        // dur=0 plays one tick; ticks during SETTLE are ignored
        write_step(0, MODE_XOR, 0);
        write_step(1, MODE_OSC0, 3);
        bus.last_step = AW'(1);
        push_exp(0, MODE_XOR);
        push_exp(1, MODE_OSC0);
        pulse_start();
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        check("t5_run0", 32'(dbg_state), 32'(ST_RUN));
        check("t5_run0_sel", 32'(bus.modulation_select), 32'(MODE_XOR));
        tick();
        check("t5_adv_sel", 32'(bus.modulation_select), 32'(MODE_OSC0));
        check("t5_adv_idx", 32'(bus.step_idx), 32'(1));
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        check("t5_run1", 32'(dbg_state), 32'(ST_RUN));
        tick();
        tick();
        check("t5_run1_after2", 32'(dbg_state), 32'(ST_RUN));
        check("t5_run1_idx", 32'(bus.step_idx), 32'(1));
        tick();
`ifdef MOD_SEQ_LOOP_EN
        check("t5_wrap_sel", 32'(bus.modulation_select), 32'(MODE_XOR));
        check("t5_wrap_state", 32'(dbg_state), 32'(ST_SETTLE));
`else
        check("t5_end_state", 32'(dbg_state), 32'(ST_DONE));
        check("t5_end_sel", 32'(bus.modulation_select), 32'(MODE_OSC0));
`endif
        pulse_stop();
        check("t5_stop_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t5_stop_done", 32'(bus.done), 32'(0));

        // Rewriting the active step only affects its next entry
        write_step(0, MODE_DIFF, 2);
        write_step(1, MODE_AND, 1);
        bus.last_step = AW'(1);
        push_exp(0, MODE_DIFF);
        push_exp(1, MODE_AND);
        pulse_start();
        step(1);
        write_step(0, MODE_XOR, 2);
        check("t6_sel_unchanged", 32'(bus.modulation_select), 32'(MODE_DIFF));
        tick();
        check("t6_sel_unchanged2", 32'(bus.modulation_select), 32'(MODE_DIFF));
        tick();
        check("t6_sel1", 32'(bus.modulation_select), 32'(MODE_AND));
        step(1);
`ifdef MOD_SEQ_LOOP_EN
        push_exp(0, MODE_XOR);
        tick();
        check("t6_reentry_sel", 32'(bus.modulation_select), 32'(MODE_XOR));
        step(1);
        check("t6_reentry_valid", 32'(bus.mod_valid), 32'(1));
`else
        tick();
        check("t6_done_sel", 32'(bus.modulation_select), 32'(MODE_AND));
        push_exp(0, MODE_XOR);
        pulse_start();
        check("t6_reentry_sel", 32'(bus.modulation_select), 32'(MODE_XOR));
        step(1);
        check("t6_reentry_valid", 32'(bus.mod_valid), 32'(1));
`endif
        pulse_stop();

        // Reset in the middle of RUN clears the table too
        bus.last_step = AW'(0);
        push_exp(0, MODE_XOR);
        pulse_start();
        step(1);
        tick();
        check("t7_run", 32'(dbg_state), 32'(ST_RUN));
        reset = 1'b1;
        step(1);
        check_idle("t7");
        reset = 1'b0;
        push_exp(0, MODE_SUM);
        pulse_start();
        check("t7_sel_after", 32'(bus.modulation_select), 32'(MODE_SUM));
        check("t7_state_after", 32'(dbg_state), 32'(ST_SETTLE));
        step(1);
        check("t7_valid_after", 32'(bus.mod_valid), 32'(1));
        tick();
`ifdef MOD_SEQ_LOOP_EN
        check("t7_wrap_valid", 32'(bus.mod_valid), 32'(0));
        check("t7_wrap_state", 32'(dbg_state), 32'(ST_SETTLE));
`else
        check("t7_done", 32'(bus.done), 32'(1));
        check("t7_done_state", 32'(dbg_state), 32'(ST_DONE));
`endif
        pulse_stop();

        step(3);
        check("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
